load_store_unit: RTL and testbench

Parametrised data-memory load/store unit for the pipelined RISC-V core. It replaces the fixed word-only data memory with an array that supports RV32I sub-word stores (SB/SH/SW) and sign- or zero-extending loads (LB/LH/LW/LBU/LHU). It also detects misaligned accesses and illegal funct3 codes, and applies a configurable wait-state latency behind a valid/ready request handshake. It sits between the MEM stage and backing storage. The MEM stage stalls while `req_ready` is low.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_lane_align.sv | 96 +++++++++
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   F3_*        : RV32I funct3 encodings for loads and stores
//   lsu_state_t : request FSM states
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for RV32I sub-word accesses.
// Ports:
//   we         : 1 = store, 0 = load
//   funct3     : RV32I funct3 of the access
//   addr_lo    : byte offset within the word (addr[1:0])
//   wdata      : store data, LSB-aligned
//   rword      : current contents of the addressed word
//   be         : store byte-enable mask (all zero on error)
//   wdata_lane : store data replicated onto the addressed lanes
//   rdata_ext  : extracted and sign/zero-extended load data
//   err        : misaligned access or illegal funct3
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the stored word.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'd0:    byte_s = rword[7:0];
      2'd1:    byte_s = rword[15:8];
      2'd2:    byte_s = rword[23:16];
      default: byte_s = rword[31:24];
    endcase
    if (addr_lo[1]) begin
      half_s = rword[31:16];
    end else begin
      half_s = rword[15:0];
    end
  end

  // Decode funct3 into enables, lane data, extension and the error flag.
  // Unsigned variants exist only for loads, so BU/HU encodings fault on stores.
  always_comb begin
    be         = 4'b0000;
    wdata_lane = 32'h0000_0000;
    rdata_ext  = 32'h0000_0000;
    err        = 1'b0;
    case (funct3)
      F3_B: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = {{24{byte_s[7]}}, byte_s};
      end
      F3_H: begin
        if (addr_lo[0]) begin
          err = 1'b1;
        end else begin
          be         = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_lane = {2{wdata[15:0]}};
          rdata_ext  = {{16{half_s[15]}}, half_s};
        end
      end
      F3_W: begin
        if (addr_lo != 2'b00) begin
          err = 1'b1;
        end else begin
          be         = 4'b1111;
          wdata_lane = wdata;
          rdata_ext  = rword;
        end
      end
      F3_BU: begin
        if (we) begin
          err = 1'b1;
        end else begin
          rdata_ext = {24'h00_0000, byte_s};
        end
      end
      F3_HU: begin
        if (we || addr_lo[0]) begin
          err = 1'b1;
        end else begin
          rdata_ext = {16'h0000, half_s};
        end
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory load/store unit with RV32I sub-word access, error detection
// and a fixed wait-state latency behind a valid/ready handshake.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   req_*        : request handshake and fields (captured on accept)
//   resp_valid   : one-cycle response pulse
//   resp_rdata   : extended load data (0 for stores, errors, idle)
//   resp_err     : misaligned or illegal access, qualified by resp_valid
//   busy         : request in flight (inverse of req_ready)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            busy
);

  localparam int AW = $clog2(DEPTH_WORDS);

  lsu_state_t      state_r, state_s;
  logic [2:0]      cnt_r, cnt_s;
  logic            ready_r, resp_valid_r, err_r;
  logic [XLEN-1:0] rdata_r, rdata_s;
  logic            we_r;
  logic [2:0]      f3_r;
  logic [AW+1:0]   addr_r;
  logic [XLEN-1:0] wdata_r;
  logic [XLEN-1:0] mem_r [0:DEPTH_WORDS-1];

  logic            accept_s, enter_resp_s, write_en_s;
  logic            cur_we_s;
  logic [2:0]      cur_f3_s;
  logic [AW+1:0]   cur_addr_s;
  logic [XLEN-1:0] cur_wdata_s;
  logic [AW-1:0]   idx_s;
  logic [XLEN-1:0] rword_s, wlane_s, rext_s;
  logic [3:0]      be_s;
  logic            align_err_s;
  logic            unused_addr_s;

  // Address bits above the array wrap away.
  assign unused_addr_s = ^req_addr[XLEN-1:AW+2];

  assign accept_s = req_valid && ready_r;

  // Next-state and wait counter; flags the edge that enters RESP.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (WAIT_STATES > 0) begin
            state_s = WAIT;
            cnt_s   = 3'(WAIT_STATES - 1);
          end else begin
            state_s      = RESP;
            enter_resp_s = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 3'd0) begin
          state_s      = RESP;
          enter_resp_s = 1'b1;
        end else begin
          cnt_s = cnt_r - 3'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        cnt_s   = 3'd0;
      end
    endcase
  end

  // With zero wait states the commit edge is the accept edge, so the live
  // request fields are used while still in IDLE.
  always_comb begin
    if (state_r == IDLE) begin
      cur_we_s    = req_we;
      cur_f3_s    = req_funct3;
      cur_addr_s  = req_addr[AW+1:0];
      cur_wdata_s = req_wdata;
    end else begin
      cur_we_s    = we_r;
      cur_f3_s    = f3_r;
      cur_addr_s  = addr_r;
      cur_wdata_s = wdata_r;
    end
  end

  assign idx_s   = cur_addr_s[AW+1:2];
  assign rword_s = mem_r[idx_s];

  lsu_lane_align u_align (
    .we         (cur_we_s),
    .funct3     (cur_f3_s),
    .addr_lo    (cur_addr_s[1:0]),
    .wdata      (cur_wdata_s),
    .rword      (rword_s),
    .be         (be_s),
    .wdata_lane (wlane_s),
    .rdata_ext  (rext_s),
    .err        (align_err_s)
  );

  assign write_en_s = enter_resp_s && cur_we_s && !align_err_s;

  // Response data is nonzero only for a good load on the commit edge.
  always_comb begin
    if (enter_resp_s && !cur_we_s && !align_err_s) begin
      rdata_s = rext_s;
    end else begin
      rdata_s = '0;
    end
  end

  // FSM state, handshake and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      cnt_r        <= 3'd0;
      ready_r      <= 1'b1;
      resp_valid_r <= 1'b0;
      err_r        <= 1'b0;
      rdata_r      <= '0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      ready_r      <= (state_s == IDLE);
      resp_valid_r <= enter_resp_s;
      err_r        <= enter_resp_s && align_err_s;
      rdata_r      <= rdata_s;
    end
  end

  // Request capture on accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r    <= 1'b0;
      f3_r    <= 3'b000;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (accept_s) begin
      we_r    <= req_we;
      f3_r    <= req_funct3;
      addr_r  <= req_addr[AW+1:0];
      wdata_r <= req_wdata;
    end
  end

  // Byte-lane array write; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (write_en_s && be_s[i]) begin
        mem_r[idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
      end
    end
  end

  assign req_ready  = ready_r;
  assign busy       = !ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = rdata_r;
  assign resp_err   = err_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. Three instances cover the latency
// configurations: u0 WAIT_STATES=1, u1 WAIT_STATES=3, u2 WAIT_STATES=0 with a
// 16-word array for the address-wrap case.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_a        [3];
  logic        req_valid_a  [3];
  logic        req_ready_a  [3];
  logic        req_we_a     [3];
  logic [2:0]  f3_a         [3];
  logic [31:0] addr_a       [3];
  logic [31:0] wdata_a      [3];
  logic        rv_a         [3];
  logic [31:0] rdata_a      [3];
  logic        err_a        [3];
  logic        busy_a       [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(1)) u0 (
    .clk(clk), .rst(rst_a[0]), .req_valid(req_valid_a[0]), .req_ready(req_ready_a[0]),
    .req_we(req_we_a[0]), .req_funct3(f3_a[0]), .req_addr(addr_a[0]), .req_wdata(wdata_a[0]),
    .resp_valid(rv_a[0]), .resp_rdata(rdata_a[0]), .resp_err(err_a[0]), .busy(busy_a[0]));

  load_store_unit #(.XLEN(32), .DEPTH_WORDS(1024), .WAIT_STATES(3)) u1 (
    .clk(clk), .rst(rst_a[1]), .req_valid(req_valid_a[1]), .req_ready(req_ready_a[1]),
    .req_we(req_we_a[1]), .req_funct3(f3_a[1]), .req_addr(addr_a[1]), .req_wdata(wdata_a[1]),
    .resp_valid(rv_a[1]), .resp_rdata(rdata_a[1]), .resp_err(err_a[1]), .busy(busy_a[1]));

  load_store_unit #(.XLEN(32), .DEPTH_WORDS(16), .WAIT_STATES(0)) u2 (
    .clk(clk), .rst(rst_a[2]), .req_valid(req_valid_a[2]), .req_ready(req_ready_a[2]),
    .req_we(req_we_a[2]), .req_funct3(f3_a[2]), .req_addr(addr_a[2]), .req_wdata(wdata_a[2]),
    .resp_valid(rv_a[2]), .resp_rdata(rdata_a[2]), .resp_err(err_a[2]), .busy(busy_a[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input int u, input string tag);
    chk({tag, "/ready"}, 32'(req_ready_a[u]), 32'd1);
    chk({tag, "/busy"},  32'(busy_a[u]),      32'd0);
    chk({tag, "/rvalid"}, 32'(rv_a[u]),       32'd0);
    chk({tag, "/rdata"}, rdata_a[u],          32'h0000_0000);
    chk({tag, "/err"},   32'(err_a[u]),       32'd0);
  endtask

  // Issue one request from an idle unit; lat counts negedges after the
  // accept edge until resp_valid is seen, -1 if it never arrives.
  task automatic do_req(input int u, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int lat);
    bit got;
    got = 1'b0;
    rd  = 32'h0000_0000;
    er  = 1'b0;
    lat = -1;
    @(negedge clk);
    req_we_a[u]    = we;
    f3_a[u]        = f3;
    addr_a[u]      = addr;
    wdata_a[u]     = wd;
    req_valid_a[u] = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a[u] = 1'b0;
    addr_a[u]      = 32'hFFFF_FFFF;
    wdata_a[u]     = 32'h5A5A_5A5A;
    for (int k = 1; k <= 12; k++) begin
      if (!got) begin
        @(negedge clk);
        if (rv_a[u] === 1'b1) begin
          got = 1'b1;
          lat = k;
          rd  = rdata_a[u];
          er  = err_a[u];
        end
      end
    end
  endtask

  task automatic txn(input string tag, input int u, input logic we, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
    logic [31:0] rd;
    logic        er;
    int          lat;
    do_req(u, we, f3, addr, wd, rd, er, lat);
    chk({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "/rdata"}, rd, exp_rd);
    chk({tag, "/err"}, 32'(er), 32'(exp_err));
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  acc;
    int  resp;
    bit  bad;
    bit  prev_ready;
    bit  seen;

    for (int u = 0; u < 3; u++) begin
      rst_a[u]       = 1'b0;
      req_valid_a[u] = 1'b0;
      req_we_a[u]    = 1'b0;
      f3_a[u]        = 3'b000;
      addr_a[u]      = 32'h0000_0000;
      wdata_a[u]     = 32'h0000_0000;
    end
    repeat (3) @(negedge clk);
    chk_idle(0, "reset_u0");
    chk_idle(1, "reset_u1");
    chk_idle(2, "reset_u2");
    for (int u = 0; u < 3; u++) rst_a[u] = 1'b1;
    @(negedge clk);
    chk_idle(0, "post_reset_u0");

    // Basic round trip, one wait state.
    txn("sw_10", 0, 1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2);
    txn("lw_10", 0, 1'b0, 3'b010, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 2);

    // Byte store only touches its lane.
    txn("sw_0_ones", 0, 1'b1, 3'b010, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 2);
    txn("sb_0",      0, 1'b1, 3'b000, 32'h0000_0000, 32'hABCD_EF00, 32'h0000_0000, 1'b0, 2);
    txn("lw_0_sb",   0, 1'b0, 3'b010, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FF00, 1'b0, 2);
    txn("lb_1",      0, 1'b0, 3'b000, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 2);
    txn("lbu_0",     0, 1'b0, 3'b100, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 2);

    // Halfword store into the upper half.
    txn("sw_4_pre", 0, 1'b1, 3'b010, 32'h0000_0004, 32'h1122_3344, 32'h0000_0000, 1'b0, 2);
    txn("sh_6",     0, 1'b1, 3'b001, 32'h0000_0006, 32'h5555_8001, 32'h0000_0000, 1'b0, 2);
    txn("lh_6",     0, 1'b0, 3'b001, 32'h0000_0006, 32'h0000_0000, 32'hFFFF_8001, 1'b0, 2);
    txn("lhu_6",    0, 1'b0, 3'b101, 32'h0000_0006, 32'h0000_0000, 32'h0000_8001, 1'b0, 2);
    txn("lw_4_sh",  0, 1'b0, 3'b010, 32'h0000_0004, 32'h0000_0000, 32'h8001_3344, 1'b0, 2);

    // Errors: no write, rdata forced to zero.
    txn("sw_0_pre",  0, 1'b1, 3'b010, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 1'b0, 2);
    txn("sw_2_mis",  0, 1'b1, 3'b010, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 2);
    txn("st_f3_011", 0, 1'b1, 3'b011, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 2);
    txn("st_f3_100", 0, 1'b1, 3'b100, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 2);
    txn("lw_0_kept", 0, 1'b0, 3'b010, 32'h0000_0000, 32'h0000_0000, 32'h1234_5678, 1'b0, 2);
    txn("ld_f3_011", 0, 1'b0, 3'b011, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b1, 2);
    txn("lh_3_mis",  0, 1'b0, 3'b001, 32'h0000_0003, 32'h0000_0000, 32'h0000_0000, 1'b1, 2);
    txn("lw_1_mis",  0, 1'b0, 3'b010, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 1'b1, 2);

    // Reset during WAIT drops the store, three wait states.
    txn("u1_sw_8", 1, 1'b1, 3'b010, 32'h0000_0008, 32'h0102_0304, 32'h0000_0000, 1'b0, 4);
    @(negedge clk);
    req_we_a[1]    = 1'b1;
    f3_a[1]        = 3'b010;
    addr_a[1]      = 32'h0000_0008;
    wdata_a[1]     = 32'hAAAA_5555;
    req_valid_a[1] = 1'b1;
    @(posedge clk);
    #1;
    req_valid_a[1] = 1'b0;
    @(negedge clk);
    chk("rst_mid/busy_in_wait", 32'(busy_a[1]), 32'd1);
    rst_a[1] = 1'b0;
    #1;
    chk("rst_mid/ready_on_assert", 32'(req_ready_a[1]), 32'd1);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rv_a[1] !== 1'b0) seen = 1'b1;
    end
    rst_a[1] = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (rv_a[1] !== 1'b0) seen = 1'b1;
    end
    chk("rst_mid/no_resp", 32'(seen), 32'd0);
    chk("rst_mid/ready_after", 32'(req_ready_a[1]), 32'd1);
    txn("u1_lw_8", 1, 1'b0, 3'b010, 32'h0000_0008, 32'h0000_0000, 32'h0102_0304, 1'b0, 4);

    // Zero wait states and address wrap on a 16-word array.
    txn("u2_sw_40", 2, 1'b1, 3'b010, 32'h0000_0040, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1);
    txn("u2_lw_0",  2, 1'b0, 3'b010, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 1);

    // req_valid held high: an accept every second cycle.
    @(negedge clk);
    req_we_a[2]    = 1'b0;
    f3_a[2]        = 3'b010;
    addr_a[2]      = 32'h0000_0000;
    req_valid_a[2] = 1'b1;
    acc        = 0;
    resp       = 0;
    bad        = 1'b0;
    prev_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (req_ready_a[2] === 1'b1) begin
        acc++;
        if (prev_ready) bad = 1'b1;
      end
      if (rv_a[2] === 1'b1) begin
        resp++;
        if (rdata_a[2] !== 32'hCAFE_F00D) bad = 1'b1;
      end else if (rdata_a[2] !== 32'h0000_0000) begin
        bad = 1'b1;
      end
      prev_ready = req_ready_a[2];
      @(negedge clk);
    end
    req_valid_a[2] = 1'b0;
    chk("held/accepts", 32'(acc), 32'd5);
    chk("held/responses", 32'(resp), 32'd5);
    chk("held/pattern", 32'(bad), 32'd0);

    @(negedge clk);
    @(negedge clk);
    chk_idle(2, "final_u2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
